// File: rtl/zxuno_io_reg_bridge.sv
// Purpose: decodes Z80 I/O cycles to the register-address/data ports and drives the register file.
// Latency: hit edge + IO_WAIT wait clocks + 1 access clock; read data presented the clock after access.
// Backpressure: holds the CPU with wait_n low through WAIT/ACCESS; read data held until iorq_n rises.
module zxuno_io_reg_bridge #(
  parameter logic [15:0] ADDR_PORT = 16'hFC3B,
  parameter logic [15:0] DATA_PORT = 16'hFD3B,
  parameter int unsigned IO_WAIT   = 2,
  parameter logic [7:0]  RESET_REG = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] a,
  input  logic [7:0]  cpu_dout,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  output logic        wait_n,
  output logic        bridge_oe,
  output logic [7:0]  cpu_din,
  output logic [7:0]  regaddr,
  output logic        reg_wr_stb,
  output logic [7:0]  reg_wdata,
  output logic        reg_rd_stb,
  input  logic [7:0]  reg_rdata
);

  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, CAPTURE, HOLD} state_t;

  localparam logic [3:0] WAIT_LOAD = (IO_WAIT == 0) ? 4'd0 : 4'(IO_WAIT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       sel_data, sel_data_nxt;   // latched port: 1 = data port, 0 = address port
  logic       is_rd, is_rd_nxt;         // latched direction
  logic [7:0] wdat, wdat_nxt;           // latched CPU write data
  logic       go_access;
  logic       hit;

  logic       wait_n_nxt, bridge_oe_nxt, reg_wr_stb_nxt, reg_rd_stb_nxt;
  logic [7:0] cpu_din_nxt, regaddr_nxt, reg_wdata_nxt;

  // Interrupt acknowledge (m1_n low) and rd+wr together are excluded here.
  assign hit = !iorq_n && m1_n && (rd_n ^ wr_n) && ((a == ADDR_PORT) || (a == DATA_PORT));

  // Next-state and next-output logic; every output is the registered copy of its _nxt value.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    sel_data_nxt   = sel_data;
    is_rd_nxt      = is_rd;
    wdat_nxt       = wdat;
    go_access      = 1'b0;
    bridge_oe_nxt  = bridge_oe;
    cpu_din_nxt    = cpu_din;
    regaddr_nxt    = regaddr;
    reg_wdata_nxt  = reg_wdata;
    reg_wr_stb_nxt = 1'b0;
    reg_rd_stb_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (hit) begin
          sel_data_nxt = (a == DATA_PORT);
          is_rd_nxt    = !rd_n;
          wdat_nxt     = cpu_dout;
          if (IO_WAIT == 0) begin
            go_access = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (iorq_n) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          go_access = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACCESS: begin
        // The address write lands at the end of ACCESS even if the CPU aborts in the
        // same clock: like the data-port strobe, the access has already happened.
        if (!is_rd && !sel_data) begin
          regaddr_nxt = wdat;
        end
        if (iorq_n) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = CAPTURE;
          if (is_rd) begin
            bridge_oe_nxt = 1'b1;
            cpu_din_nxt   = sel_data ? reg_rdata : regaddr;
          end
        end
      end
      CAPTURE: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (iorq_n) begin
          state_nxt     = IDLE;
          bridge_oe_nxt = 1'b0;
          cpu_din_nxt   = 8'hFF;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Strobes are raised on the edge entering ACCESS, so they are high exactly during ACCESS.
    if (go_access) begin
      state_nxt      = ACCESS;
      reg_wr_stb_nxt = !is_rd_nxt && sel_data_nxt;
      reg_rd_stb_nxt = is_rd_nxt && sel_data_nxt;
      if (!is_rd_nxt && sel_data_nxt) begin
        reg_wdata_nxt = wdat_nxt;
      end
    end

    wait_n_nxt = !((state_nxt == WAIT) || (state_nxt == ACCESS));
  end

  // State, latched cycle info and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      sel_data   <= 1'b0;
      is_rd      <= 1'b0;
      wdat       <= 8'h00;
      wait_n     <= 1'b1;
      bridge_oe  <= 1'b0;
      cpu_din    <= 8'hFF;
      regaddr    <= RESET_REG;
      reg_wr_stb <= 1'b0;
      reg_wdata  <= 8'h00;
      reg_rd_stb <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sel_data   <= sel_data_nxt;
      is_rd      <= is_rd_nxt;
      wdat       <= wdat_nxt;
      wait_n     <= wait_n_nxt;
      bridge_oe  <= bridge_oe_nxt;
      cpu_din    <= cpu_din_nxt;
      regaddr    <= regaddr_nxt;
      reg_wr_stb <= reg_wr_stb_nxt;
      reg_wdata  <= reg_wdata_nxt;
      reg_rd_stb <= reg_rd_stb_nxt;
    end
  end

endmodule
